// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler.
// Holds the phase encodings, the phase output width, the default phase
// durations, the lamp bundle type and the state-to-lamp decode function.
package intersection_phase_scheduler_pkg;

  localparam int PHASE_W             = 3;
  localparam int DEF_WIDTH_TIMER     = 4;
  localparam int DEF_GREEN_TIME      = 10;
  localparam int DEF_YELLOW_TIME     = 3;
  localparam int DEF_ALLRED_TIME     = 1;
  localparam int DEF_WALK_TIME       = 6;

  typedef enum logic [PHASE_W-1:0] {
    ST_ALL_RED   = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_WALK      = 3'd5,
    ST_EMERG     = 3'd6
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  typedef struct packed {
    logic ns_green;
    logic ns_yellow;
    logic ns_red;
    logic ew_green;
    logic ew_yellow;
    logic ew_red;
    logic walk;
    logic emerg_active;
  } lamps_t;

  // Unknown encodings decode as all-red so a corrupted state never lights
  // a green while the FSM recovers.
  function automatic lamps_t decode_lamps(input phase_e st);
    lamps_t l;
    l = '0;
    case (st)
      ST_NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
      ST_NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
      ST_EW_GREEN:  begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
      ST_EW_YELLOW: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
      ST_WALK:      begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
      ST_EMERG:     begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.emerg_active = 1'b1; end
      default:      begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_timer.sv
// phase_timer: loadable down-counter that times one phase.
// Ports:
//   clk        - clock, rising edge
//   load       - reload the counter (wins over counting)
//   load_value - phase length in cycles, must be >= 1
//   done       - high on the last cycle of the phase
// The counter holds load_value on the entry cycle and counts down, so a
// phase of length N ends on the cycle the counter reads 1. There is no
// reset port: the owner asserts load during reset.
module phase_timer #(
  parameter int WIDTH_TIMER = 4
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [WIDTH_TIMER-1:0] load_value,
  output logic                   done
);

  logic [WIDTH_TIMER-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Zero is treated as expired too, so a stalled counter can never hang a phase.
  assign done = (count == '0) || (count == WIDTH_TIMER'(1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: two-way intersection controller with
// pedestrian walk phase and emergency preemption.
// Ports:
//   clk, rstn            - clock and synchronous active-low reset
//   ns_req, ew_req       - vehicle sensors (level)
//   ped_req              - pedestrian button (any-length pulse)
//   emerg_req            - emergency preempt (level)
//   ns_*/ew_* lamps      - one-hot per direction, registered
//   walk, emerg_active   - walk lamp and preempt indicator, registered
//   ped_pending          - latched pedestrian request
//   phase                - current state encoding
//
// state        | meaning
// ALL_RED   0  | clearance; picks next phase on expiry
// NS_GREEN  1  | NS go, extends while nothing else is waiting
// NS_YELLOW 2  | NS clearing
// EW_GREEN  3  | EW go, extends while nothing else is waiting
// EW_YELLOW 4  | EW clearing
// WALK      5  | pedestrian crossing, both directions red
// EMERG     6  | preempt, held while emerg_req is high
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int WIDTH_TIMER = DEF_WIDTH_TIMER,
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int ALLRED_TIME = DEF_ALLRED_TIME,
  parameter int WALK_TIME   = DEF_WALK_TIME
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ns_req,
  input  logic               ew_req,
  input  logic               ped_req,
  input  logic               emerg_req,
  output logic               ns_green,
  output logic               ns_yellow,
  output logic               ns_red,
  output logic               ew_green,
  output logic               ew_yellow,
  output logic               ew_red,
  output logic               walk,
  output logic               emerg_active,
  output logic               ped_pending,
  output logic [PHASE_W-1:0] phase
);

  // A zero duration is promoted to one cycle.
  localparam logic [WIDTH_TIMER-1:0] GREEN_LD  =
    (GREEN_TIME  == 0) ? WIDTH_TIMER'(1) : WIDTH_TIMER'(GREEN_TIME);
  localparam logic [WIDTH_TIMER-1:0] YELLOW_LD =
    (YELLOW_TIME == 0) ? WIDTH_TIMER'(1) : WIDTH_TIMER'(YELLOW_TIME);
  localparam logic [WIDTH_TIMER-1:0] ALLRED_LD =
    (ALLRED_TIME == 0) ? WIDTH_TIMER'(1) : WIDTH_TIMER'(ALLRED_TIME);
  localparam logic [WIDTH_TIMER-1:0] WALK_LD   =
    (WALK_TIME   == 0) ? WIDTH_TIMER'(1) : WIDTH_TIMER'(WALK_TIME);

  phase_e                 state;
  phase_e                 state_next;
  dir_e                   last_served;
  lamps_t                 lamps;
  logic                   extend;
  logic                   timer_load;
  logic [WIDTH_TIMER-1:0] timer_value;
  logic                   timer_done;

  phase_timer #(.WIDTH_TIMER(WIDTH_TIMER)) u_timer (
    .clk        (clk),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_comb begin
    state_next = state;
    extend     = 1'b0;
    case (state)
      ST_ALL_RED: begin
        if (timer_done) begin
          if (emerg_req) begin
            state_next = ST_EMERG;
          end else if (ped_pending) begin
            state_next = ST_WALK;
          end else if (last_served == DIR_EW) begin
            // NS was not served last: it wins unless only EW is asking.
            state_next = (!ns_req && ew_req) ? ST_EW_GREEN : ST_NS_GREEN;
          end else begin
            state_next = (!ew_req && ns_req) ? ST_NS_GREEN : ST_EW_GREEN;
          end
        end
      end
      ST_NS_GREEN: begin
        // Any emerg_req seen in green is a fresh rise: green is only
        // entered from ALL_RED with emerg_req low.
        if (emerg_req) begin
          state_next = ST_NS_YELLOW;
        end else if (timer_done) begin
          if (ew_req || ped_pending) state_next = ST_NS_YELLOW;
          else                       extend     = 1'b1;
        end
      end
      ST_EW_GREEN: begin
        if (emerg_req) begin
          state_next = ST_EW_YELLOW;
        end else if (timer_done) begin
          if (ns_req || ped_pending) state_next = ST_EW_YELLOW;
          else                       extend     = 1'b1;
        end
      end
      ST_NS_YELLOW, ST_EW_YELLOW, ST_WALK: begin
        if (timer_done) state_next = ST_ALL_RED;
      end
      ST_EMERG: begin
        if (!emerg_req) state_next = ST_ALL_RED;
      end
      default: state_next = ST_ALL_RED;
    endcase
  end

  always_comb begin
    timer_load  = !rstn || (state_next != state) || extend;
    timer_value = ALLRED_LD;
    if (rstn) begin
      case (state_next)
        ST_NS_GREEN, ST_EW_GREEN:   timer_value = GREEN_LD;
        ST_NS_YELLOW, ST_EW_YELLOW: timer_value = YELLOW_LD;
        ST_WALK:                    timer_value = WALK_LD;
        default:                    timer_value = ALLRED_LD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_ALL_RED;
      last_served <= DIR_EW;
      ped_pending <= 1'b0;
      lamps       <= decode_lamps(ST_ALL_RED);
    end else begin
      state <= state_next;
      lamps <= decode_lamps(state_next);
      if (state_next == ST_NS_GREEN && state != ST_NS_GREEN) last_served <= DIR_NS;
      if (state_next == ST_EW_GREEN && state != ST_EW_GREEN) last_served <= DIR_EW;
      // Entering WALK consumes the request; a press during WALK re-arms it.
      if (state_next == ST_WALK && state != ST_WALK) ped_pending <= 1'b0;
      else                                           ped_pending <= ped_pending | ped_req;
    end
  end

  assign ns_green     = lamps.ns_green;
  assign ns_yellow    = lamps.ns_yellow;
  assign ns_red       = lamps.ns_red;
  assign ew_green     = lamps.ew_green;
  assign ew_yellow    = lamps.ew_yellow;
  assign ew_red       = lamps.ew_red;
  assign walk         = lamps.walk;
  assign emerg_active = lamps.emerg_active;
  assign phase        = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with default parameters.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rstn, ns_req, ew_req, ped_req, emerg_req;
  logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
  logic       walk, emerg_active, ped_pending;
  logic [2:0] phase;
  logic       mon_en = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk          (clk),
    .rstn         (rstn),
    .ns_req       (ns_req),
    .ew_req       (ew_req),
    .ped_req      (ped_req),
    .emerg_req    (emerg_req),
    .ns_green     (ns_green),
    .ns_yellow    (ns_yellow),
    .ns_red       (ns_red),
    .ew_green     (ew_green),
    .ew_yellow    (ew_yellow),
    .ew_red       (ew_red),
    .walk         (walk),
    .emerg_active (emerg_active),
    .ped_pending  (ped_pending),
    .phase        (phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, emerg}
  function automatic logic [7:0] exp_lamps(input logic [2:0] p);
    case (p)
      3'd1:    return 8'b100_001_00;
      3'd2:    return 8'b010_001_00;
      3'd3:    return 8'b001_100_00;
      3'd4:    return 8'b001_010_00;
      3'd5:    return 8'b001_001_10;
      3'd6:    return 8'b001_001_01;
      default: return 8'b001_001_00;
    endcase
  endfunction

  // Lamp invariants checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ns_one_lamp", $countones({ns_green, ns_yellow, ns_red}), 1);
      check("ew_one_lamp", $countones({ew_green, ew_yellow, ew_red}), 1);
      check("both_green", {31'd0, ns_green & ew_green}, 0);
      check("lamp_decode",
            {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, emerg_active},
            exp_lamps(phase));
    end
  end

  // Advance n cycles, checking the phase at each negedge.
  task automatic expect_phase(input logic [2:0] p, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, phase, p);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_lamps"},
          {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, emerg_active},
          8'b001_001_00);
    check({tag, "_ped"}, ped_pending, 0);
  endtask

  // Leaves the bench at the negedge of the first ALL_RED cycle, reset released.
  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0; emerg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    mon_en = 1'b1;

    // Both directions demanding: plain alternation, period 28.
    ns_req = 1'b1; ew_req = 1'b1;
    rstn = 1'b1;
    expect_phase(3'd1, 10, "alt_ns_green");
    expect_phase(3'd2, 3,  "alt_ns_yellow");
    expect_phase(3'd0, 1,  "alt_allred1");
    expect_phase(3'd3, 10, "alt_ew_green");
    expect_phase(3'd4, 3,  "alt_ew_yellow");
    expect_phase(3'd0, 1,  "alt_allred2");
    expect_phase(3'd1, 1,  "alt_wrap_ns");

    // NS only: green extends until EW asks, then yellow at the next boundary.
    ns_req = 1'b1; ew_req = 1'b0;
    do_reset();
    check("ext_start", phase, 0);
    expect_phase(3'd1, 24, "ext_green");
    ew_req = 1'b1;
    expect_phase(3'd1, 6, "ext_green_tail");
    expect_phase(3'd2, 3, "ext_yellow");
    expect_phase(3'd0, 1, "ext_allred");
    expect_phase(3'd3, 1, "ext_ew_green");

    // Pedestrian pulse during NS green.
    ns_req = 1'b1; ew_req = 1'b1;
    do_reset();
    expect_phase(3'd1, 2, "ped_green_a");
    ped_req = 1'b1;
    expect_phase(3'd1, 1, "ped_green_b");
    ped_req = 1'b0;
    check("ped_latched", ped_pending, 1);
    expect_phase(3'd1, 7, "ped_green_c");
    expect_phase(3'd2, 3, "ped_yellow");
    expect_phase(3'd0, 1, "ped_allred1");
    expect_phase(3'd5, 1, "ped_walk_entry");
    check("ped_walk_lamp", walk, 1);
    check("ped_cleared", ped_pending, 0);
    check("ped_reds", {ns_red, ew_red}, 2'b11);
    expect_phase(3'd5, 5, "ped_walk");
    expect_phase(3'd0, 1, "ped_allred2");
    expect_phase(3'd3, 1, "ped_ew_green");

    // Emergency on the 4th cycle of EW green.
    expect_phase(3'd3, 3, "em_ew_green");
    emerg_req = 1'b1;
    expect_phase(3'd4, 3, "em_ew_yellow");
    expect_phase(3'd0, 1, "em_allred1");
    expect_phase(3'd6, 20, "em_hold");
    check("em_active", emerg_active, 1);
    emerg_req = 1'b0;
    expect_phase(3'd0, 1, "em_allred2");
    expect_phase(3'd1, 1, "em_ns_green");

    // Reset in the middle of EW yellow.
    expect_phase(3'd1, 9,  "rst_ns_green");
    expect_phase(3'd2, 3,  "rst_ns_yellow");
    expect_phase(3'd0, 1,  "rst_allred");
    expect_phase(3'd3, 10, "rst_ew_green");
    expect_phase(3'd4, 1,  "rst_ew_yellow");
    rstn = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rstn = 1'b1;
    expect_phase(3'd1, 10, "re_ns_green");
    expect_phase(3'd2, 3,  "re_ns_yellow");
    expect_phase(3'd0, 1,  "re_allred");
    expect_phase(3'd3, 1,  "re_ew_green");

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
